// File: rtl/button_press_classifier_pkg.sv
// Shared definitions for the button press classifier.
// Holds the FSM state type and the default timing parameters used by the
// top module when no overrides are given.
package button_press_classifier_pkg;

  // Gesture tracking states; 3 bits leaves room for all five encodings.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_GAP       = 3'd2,
    ST_PRESS2    = 3'd3,
    ST_LONG_HELD = 3'd4
  } state_e;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_LONG_CYCLES = 50000;
  localparam int DEF_GAP_CYCLES  = 20000;

endpackage : button_press_classifier_pkg

// File: rtl/button_press_classifier.sv
// Classifies debounced button gestures into short, long and double presses.
// Each gesture yields at most one single-cycle event pulse.
//
// Ports:
//   clk          - rising-edge clock
//   rst          - synchronous reset, active-high
//   clean_in     - debounced button level
//   short_press  - one-cycle pulse: press then a full gap with no second press
//   long_press   - one-cycle pulse: first press held LONG_CYCLES samples
//   double_press - one-cycle pulse: second press within the gap window
//   held         - level, high while a long (or long double) press is held
//   busy         - level, high whenever a gesture is in progress
module button_press_classifier
  import button_press_classifier_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LONG_CYCLES = DEF_LONG_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clean_in,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic held,
  output logic busy
);

  // The counter holds k-1 while the k-th sample of a run is being examined,
  // so the terminal compare values are one less than the cycle counts.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_q;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;
  logic             rise;

  assign rise = clean_in & ~prev_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_PRESS1;
          cnt_d   = CNT_ONE;
        end
      end

      ST_PRESS1: begin
        if (clean_in) begin
          if (cnt_q == LONG_LAST) begin
            long_d  = 1'b1;
            state_d = ST_LONG_HELD;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = ST_GAP;
          cnt_d   = CNT_ONE;
        end
      end

      ST_GAP: begin
        // A press arriving on the expiry sample wins: it is a double press.
        if (clean_in) begin
          state_d = ST_PRESS2;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == GAP_LAST) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_PRESS2: begin
        if (!clean_in) begin
          double_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (cnt_q == LONG_LAST) begin
          // Holding the second press long still reports a double press only.
          double_d = 1'b1;
          state_d  = ST_LONG_HELD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_LONG_HELD: begin
        // Release after a long hold is silent.
        if (!clean_in) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      // prev resets high so a button held through reset is not seen as a rise.
      prev_q   <= 1'b1;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= clean_in;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = double_q;
  assign held         = (state_q == ST_LONG_HELD);
  assign busy         = (state_q != ST_IDLE);

endmodule : button_press_classifier
